// File: rtl/lz77_decoder_stream.sv
// ---------------------------------------------------------------------------
// lz77_decoder_stream
//   Streaming LZ77 decoder. Each accepted code triple (pos, len, char) expands
//   to len characters copied out of a sliding search buffer, followed by the
//   literal char. The buffer shifts by one entry for every character handed to
//   the sink, so entry 0 is always the newest decoded character. Emitting the
//   terminator literal halts the decoder until reset.
//
// Ports
//   clk         in   1       rising-edge clock
//   reset       in   1       asynchronous, active-low reset
//   code_valid  in   1       code triple valid
//   code_ready  out  1       triple accepted this cycle when code_valid=1
//   code_pos    in   POS_W   copy source index (0 = newest char)
//   code_len    in   LEN_W   chars copied before the literal (0 = literal only)
//   chardata    in   DATA_W  literal appended after the copy
//   char_valid  out  1       char_nxt valid
//   char_ready  in   1       sink takes char_nxt this cycle
//   char_nxt    out  DATA_W  decoded character
//   finish      out  1       sticky: terminator emitted, decoder halted
//   busy        out  1       decoder is in COPY or LIT
//
// Handshakes: a beat moves on a channel exactly in a cycle where valid and
// ready are both high at the rising edge. A producer holding valid keeps its
// payload stable until the beat moves; valid never waits on ready. The only
// input-to-output path is char_ready -> code_ready, which lets the next triple
// be taken in the same cycle the current literal leaves (no bubble).
// ---------------------------------------------------------------------------
module lz77_decoder_stream #(
    parameter int                DATA_W       = 8,
    parameter int                SEARCH_DEPTH = 16,
    parameter int                POS_W        = $clog2(SEARCH_DEPTH),
    parameter int                LEN_W        = 4,
    parameter logic [DATA_W-1:0] TERM_CHAR    = 8'h24
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              code_valid,
    output logic              code_ready,
    input  logic [POS_W-1:0]  code_pos,
    input  logic [LEN_W-1:0]  code_len,
    input  logic [DATA_W-1:0] chardata,
    output logic              char_valid,
    input  logic              char_ready,
    output logic [DATA_W-1:0] char_nxt,
    output logic              finish,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_COPY = 2'd1,
        S_LIT  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [DATA_W-1:0]   r_buf [SEARCH_DEPTH];
    logic [LEN_W-1:0]    r_cnt;
    logic [POS_W-1:0]    r_pos;
    logic [LEN_W-1:0]    r_len;
    logic [DATA_W-1:0]   r_char;
    logic                w_xfer;
    logic                w_accept;
    logic                w_copy_last;

    // Outputs derive from registers only, so a stalled character stays put.
    assign char_valid = (r_state == S_COPY) || (r_state == S_LIT);
    assign char_nxt   = (r_state == S_COPY) ? r_buf[r_pos] :
                        (r_state == S_LIT)  ? r_char       : '0;
    assign code_ready = (r_state == S_IDLE) ||
                        ((r_state == S_LIT) && char_ready && (r_char != TERM_CHAR));
    assign finish     = (r_state == S_DONE);
    assign busy       = char_valid;

    assign w_xfer      = char_valid && char_ready;
    assign w_accept    = code_valid && code_ready;
    // r_len is non-zero whenever COPY is entered, so len-1 never underflows.
    assign w_copy_last = (r_cnt == (r_len - LEN_W'(1)));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_state_nxt = (code_len != '0) ? S_COPY : S_LIT;
            end
            S_COPY: begin
                if (w_xfer && w_copy_last) w_state_nxt = S_LIT;
            end
            S_LIT: begin
                if (w_xfer) begin
                    if (r_char == TERM_CHAR) w_state_nxt = S_DONE;
                    else if (w_accept)       w_state_nxt = (code_len != '0) ? S_COPY : S_LIT;
                    else                     w_state_nxt = S_IDLE;
                end
            end
            S_DONE:  w_state_nxt = S_DONE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_pos   <= '0;
            r_len   <= '0;
            r_char  <= '0;
            for (int i = 0; i < SEARCH_DEPTH; i++) r_buf[i] <= '0;
        end else begin
            r_state <= w_state_nxt;
            // Every emitted char (copied or literal) enters the history.
            if (w_xfer) begin
                for (int i = SEARCH_DEPTH - 1; i > 0; i--) r_buf[i] <= r_buf[i-1];
                r_buf[0] <= char_nxt;
            end
            if (w_accept) begin
                r_pos  <= code_pos;
                r_len  <= code_len;
                r_char <= chardata;
                r_cnt  <= '0;
            end else if (w_xfer && (r_state == S_COPY)) begin
                r_cnt <= r_cnt + LEN_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_lz77_decoder_stream.sv
module tb_lz77_decoder_stream;

  localparam int          DATA_W = 8;
  localparam int          POS_W  = 4;
  localparam int          LEN_W  = 4;
  localparam logic [7:0]  TERM   = 8'h24;
  localparam int          BUDGET = 3000;

  // ---------------- clock / reset ----------------
  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              code_valid = 1'b0;
  logic              code_ready;
  logic [POS_W-1:0]  code_pos = '0;
  logic [LEN_W-1:0]  code_len = '0;
  logic [DATA_W-1:0] chardata = '0;
  logic              char_valid;
  logic              char_ready = 1'b0;
  logic [DATA_W-1:0] char_nxt;
  logic              finish;
  logic              busy;

  always #5 clk = ~clk;

  lz77_decoder_stream #(
    .DATA_W(DATA_W), .SEARCH_DEPTH(16), .POS_W(POS_W), .LEN_W(LEN_W), .TERM_CHAR(TERM)
  ) dut (
    .clk(clk), .reset(reset),
    .code_valid(code_valid), .code_ready(code_ready),
    .code_pos(code_pos), .code_len(code_len), .chardata(chardata),
    .char_valid(char_valid), .char_ready(char_ready), .char_nxt(char_nxt),
    .finish(finish), .busy(busy)
  );

  // ---------------- scoreboard / reference model ----------------
  int n_cmp = 0;
  int n_bad = 0;

  logic [DATA_W-1:0] exp_q[$];   // expected output characters in order
  bit                lit_q[$];   // 1 where the expected char is a literal
  logic [DATA_W-1:0] hist[$];    // decoded history, newest at index 0
  int                tp[$];
  int                tl[$];
  logic [DATA_W-1:0] tc[$];
  bit                fin_exp;
  bit                model_done;
  int                idx;
  int                first_xf;
  int                last_xf;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    exp_q.delete(); lit_q.delete(); hist.delete();
    tp.delete(); tl.delete(); tc.delete();
    fin_exp = 0; model_done = 0;
  endtask

  // Expand a triple with plain history lookups; unknown history reads 0.
  task automatic add_triple(input int p, input int l, input logic [DATA_W-1:0] c);
    logic [DATA_W-1:0] v;
    tp.push_back(p); tl.push_back(l); tc.push_back(c);
    if (model_done) return;
    for (int k = 0; k < l; k++) begin
      v = (p < hist.size()) ? hist[p] : '0;
      hist.push_front(v);
      exp_q.push_back(v); lit_q.push_back(1'b0);
    end
    hist.push_front(c);
    exp_q.push_back(c); lit_q.push_back(1'b1);
    if (c == TERM) model_done = 1;
  endtask

  task automatic do_reset();
    reset = 1'b0; code_valid = 1'b0; char_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    clear_model();
  endtask

  // ---------------- driver + monitor ----------------
  // rmode: 0 always ready, 1 pattern 1,0,0,..., 2 random. vmode: 0 eager, 1 random gaps.
  task automatic run(input int rmode, input int vmode, input int max_xf);
    int  nx = 0;
    int  cyc = 0;
    bit  prev_stall = 0;
    bit  fin_next = 0;
    bit  xf, acc;
    logic [DATA_W-1:0] prev_char = '0;
    idx = 0; first_xf = -1; last_xf = -1;
    while (exp_q.size() > 0 && cyc < BUDGET && nx < max_xf) begin
      @(negedge clk);
      case (rmode)
        0:       char_ready = 1'b1;
        1:       char_ready = (cyc % 3 == 0);
        default: char_ready = 1'($urandom_range(0, 1));
      endcase
      code_valid = (idx < tp.size()) && (vmode == 0 || $urandom_range(0, 1) == 1);
      if (idx < tp.size() && code_valid) begin
        code_pos = POS_W'(tp[idx]); code_len = LEN_W'(tl[idx]); chardata = tc[idx];
      end else begin
        code_pos = POS_W'($urandom); code_len = LEN_W'($urandom); chardata = 8'($urandom);
      end
      #1;
      if (prev_stall) begin
        check("stall_valid", char_valid, 1);
        check("stall_data", char_nxt, prev_char);
      end
      check("finish", finish, fin_exp);
      xf  = char_valid && char_ready;
      acc = code_valid && code_ready;
      if (xf) begin
        check("char", char_nxt, exp_q[0]);
        check("ready_on_xfer", code_ready, lit_q[0] && (exp_q[0] != TERM));
        if (lit_q[0] && exp_q[0] == TERM) fin_next = 1;
        void'(exp_q.pop_front()); void'(lit_q.pop_front());
        if (first_xf < 0) first_xf = cyc;
        last_xf = cyc;
      end
      prev_stall = char_valid && !char_ready;
      prev_char  = char_nxt;
      @(posedge clk);
      if (acc) idx++;
      if (xf) nx++;
      if (fin_next) fin_exp = 1;
      cyc++;
    end
    if (cyc >= BUDGET) begin
      n_cmp++; n_bad++;
      $error("FAIL timeout: observed %0d chars pending expected 0", exp_q.size());
    end
  endtask

  // After the stream drains: no stray chars, and the halt/idle state is right.
  task automatic tail();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      char_ready = 1'($urandom_range(0, 1));
      code_valid = fin_exp ? 1'b1 : 1'b0;
      #1;
      check("no_extra_char", char_valid, 0);
      check("tail_finish", finish, fin_exp);
      check("tail_busy", busy, 0);
      check("tail_code_ready", code_ready, fin_exp ? 0 : 1);
    end
    code_valid = 1'b0;
  endtask

  task automatic rand_char(output logic [DATA_W-1:0] c);
    c = 8'($urandom);
    if (c == TERM) c = 8'h25;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [DATA_W-1:0] rc;
    int nt;

    // Reset state
    do_reset();
    #1;
    check("rst_code_ready", code_ready, 1);
    check("rst_char_valid", char_valid, 0);
    check("rst_char_nxt", char_nxt, 0);
    check("rst_finish", finish, 0);
    check("rst_busy", busy, 0);

    // 1: basic stream ending in the terminator; trailing triple must be ignored
    add_triple(0, 0, "a"); add_triple(0, 0, "b"); add_triple(1, 3, "c");
    add_triple(0, 0, TERM); add_triple(2, 2, "z");
    run(0, 0, 1000); tail();

    // 2: overlapping run copy
    do_reset();
    add_triple(0, 0, "x"); add_triple(0, 5, "y");
    run(0, 0, 1000); tail();

    // 3: scenario 1 under back-pressure
    do_reset();
    add_triple(0, 0, "a"); add_triple(0, 0, "b"); add_triple(1, 3, "c"); add_triple(0, 0, TERM);
    run(1, 0, 1000); tail();

    // 4: zero-bubble literal stream
    do_reset();
    add_triple(0, 0, "p"); add_triple(0, 0, "q"); add_triple(0, 0, "r"); add_triple(0, 0, "s");
    run(0, 0, 1000);
    check("zero_bubble_span", 32'(last_xf - first_xf + 1), 4);
    tail();

    // 5: maximum copy length
    do_reset();
    add_triple(0, 0, "k"); add_triple(0, 15, "z");
    run(0, 0, 1000); tail();

    // 6: reset in the middle of a copy, then decode from a cleared buffer
    do_reset();
    add_triple(0, 0, "A"); add_triple(0, 0, "B"); add_triple(0, 0, "C"); add_triple(0, 0, "D");
    add_triple(1, 7, "q");
    run(0, 0, 6);
    #1;
    check("mid_copy_busy", busy, 1);
    #2;
    reset = 1'b0; code_valid = 1'b0;
    #1;
    check("abort_char_valid", char_valid, 0);
    check("abort_char_nxt", char_nxt, 0);
    check("abort_finish", finish, 0);
    check("abort_busy", busy, 0);
    @(negedge clk);
    reset = 1'b1;
    clear_model();
    add_triple(3, 2, "m");
    run(0, 0, 1000); tail();

    // Random streams against the reference model
    for (int r = 0; r < 8; r++) begin
      do_reset();
      nt = $urandom_range(6, 16);
      for (int t = 0; t < nt; t++) begin
        rand_char(rc);
        add_triple($urandom_range(0, 15), $urandom_range(0, 15), rc);
      end
      if (r % 2 == 0) add_triple($urandom_range(0, 15), $urandom_range(0, 15), TERM);
      run(2, 1, 100000); tail();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
